branch_resolve_unit: RTL and testbench

EX-stage consumer of the branch comparator flags. It accepts one branch or jump per handshake and drives the comparator's operands and enable. It samples the resulting flags, decides taken/not-taken (static not-taken prediction) and computes the target. On a taken branch it issues a redirect to fetch over a valid/ready handshake, then flushes the younger pipeline stages for a fixed number of cycles.

---
 rtl/branch_pkg.sv | 21 ++
 rtl/branch_resolve_unit_decide.sv | 53 +++++
 rtl/branch_resolve_unit.sv | 174 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and encodings for the EX-stage branch resolve unit.
package branch_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CMP      = 3'd1,
      S_EVAL     = 3'd2,
      S_REDIRECT = 3'd3,
      S_FLUSH    = 3'd4
   } br_state_t;

endpackage

// File: rtl/branch_resolve_unit_decide.sv
// Combinational branch decision: condition from funct3 and comparator flags,
// target address, misalignment and link address.
module branch_decide
   import branch_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2:0]      i_funct3,
   input  logic            i_is_jal,
   input  logic            i_is_jalr,
   input  logic            i_eq,
   input  logic            i_lt,
   input  logic            i_ltu,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_rs1,
   output logic            o_taken,
   output logic            o_illegal,
   output logic            o_misalign,
   output logic [XLEN-1:0] o_target,
   output logic [XLEN-1:0] o_link_pc
);

   logic            w_cond;
   logic            w_bad_f3;
   logic            w_jump;
   logic [XLEN-1:0] w_sum;

   always_comb begin
      w_cond   = 1'b0;
      w_bad_f3 = 1'b0;
      case (i_funct3)
         F3_BEQ:  w_cond = i_eq;
         F3_BNE:  w_cond = ~i_eq;
         F3_BLT:  w_cond = i_lt;
         F3_BGE:  w_cond = ~i_lt;
         F3_BLTU: w_cond = i_ltu;
         F3_BGEU: w_cond = ~i_ltu;
         default: w_bad_f3 = 1'b1;
      endcase
   end

   // Jump flags override whatever happens to be in funct3.
   assign w_jump    = i_is_jal | i_is_jalr;
   assign o_taken   = w_jump | w_cond;
   assign o_illegal = ~w_jump & w_bad_f3;

   assign w_sum      = (i_is_jalr ? i_rs1 : i_pc) + i_imm;
   assign o_target   = i_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
   assign o_misalign = o_taken & o_target[1];
   assign o_link_pc  = i_pc + XLEN'(4);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: drives the comparator, decides the outcome,
// redirects fetch on taken branches and flushes the younger stages.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | br_ready high, waiting for a branch/jump request
// S_CMP      | comparator enabled on the captured operands
// S_EVAL     | flags valid; decide, count, pulse link/illegal/misalign
// S_REDIRECT | redirect_valid held until fetch accepts
// S_FLUSH    | flush held for FLUSH_CYCLES cycles
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_funct3,
   input  logic             br_is_jal,
   input  logic             br_is_jalr,
   input  logic [XLEN-1:0]  br_pc,
   input  logic [XLEN-1:0]  br_imm,
   input  logic [XLEN-1:0]  rs1_in,
   input  logic [XLEN-1:0]  rs2_in,
   output logic [XLEN-1:0]  cmp_rs1_value,
   output logic [XLEN-1:0]  cmp_rs2_value,
   output logic             enable_branch_cmp,
   input  logic             EQ_flag,
   input  logic             LT_flag,
   input  logic             LTU_flag,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush,
   output logic             link_valid,
   output logic [XLEN-1:0]  link_pc,
   output logic             misalign_exc,
   output logic             illegal_br,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   br_state_t        r_state;
   br_state_t        w_next;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_imm;
   logic [2:0]       r_funct3;
   logic             r_is_jal;
   logic             r_is_jalr;
   logic [XLEN-1:0]  r_rs1;
   logic [XLEN-1:0]  r_rs2;
   logic [XLEN-1:0]  r_redirect_pc;
   logic [FC_W-1:0]  r_flush_cnt;
   logic [CNT_W-1:0] r_branch_count;
   logic [CNT_W-1:0] r_taken_count;

   logic             w_taken;
   logic             w_illegal;
   logic             w_misalign;
   logic [XLEN-1:0]  w_target;
   logic [XLEN-1:0]  w_link_pc;
   logic             w_is_jump;

   branch_decide #(.XLEN(XLEN)) u_decide (
      .i_funct3   (r_funct3),
      .i_is_jal   (r_is_jal),
      .i_is_jalr  (r_is_jalr),
      .i_eq       (EQ_flag),
      .i_lt       (LT_flag),
      .i_ltu      (LTU_flag),
      .i_pc       (r_pc),
      .i_imm      (r_imm),
      .i_rs1      (r_rs1),
      .o_taken    (w_taken),
      .o_illegal  (w_illegal),
      .o_misalign (w_misalign),
      .o_target   (w_target),
      .o_link_pc  (w_link_pc)
   );

   assign w_is_jump = r_is_jal | r_is_jalr;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next            = r_state;
      br_ready          = 1'b0;
      enable_branch_cmp = 1'b0;
      redirect_valid    = 1'b0;
      flush             = 1'b0;
      link_valid        = 1'b0;
      link_pc           = '0;
      misalign_exc      = 1'b0;
      illegal_br        = 1'b0;
      case (r_state)
         S_IDLE: begin
            br_ready = 1'b1;
            if (br_valid) w_next = S_CMP;
         end
         S_CMP: begin
            enable_branch_cmp = 1'b1;
            w_next            = S_EVAL;
         end
         S_EVAL: begin
            link_valid   = w_is_jump;
            link_pc      = w_is_jump ? w_link_pc : '0;
            illegal_br   = w_illegal;
            misalign_exc = w_misalign;
            w_next       = (w_taken && !w_misalign) ? S_REDIRECT : S_IDLE;
         end
         S_REDIRECT: begin
            redirect_valid = 1'b1;
            if (redirect_ready) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            flush = 1'b1;
            if (r_flush_cnt == '0) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc           <= '0;
         r_imm          <= '0;
         r_funct3       <= '0;
         r_is_jal       <= 1'b0;
         r_is_jalr      <= 1'b0;
         r_rs1          <= '0;
         r_rs2          <= '0;
         r_redirect_pc  <= '0;
         r_flush_cnt    <= '0;
         r_branch_count <= '0;
         r_taken_count  <= '0;
      end else begin
         if (r_state == S_IDLE && br_valid) begin
            r_pc      <= br_pc;
            r_imm     <= br_imm;
            r_funct3  <= br_funct3;
            r_is_jal  <= br_is_jal;
            r_is_jalr <= br_is_jalr;
            r_rs1     <= rs1_in;
            r_rs2     <= rs2_in;
         end
         if (r_state == S_EVAL) begin
            r_branch_count <= r_branch_count + CNT_W'(1);
            if (w_taken) r_taken_count <= r_taken_count + CNT_W'(1);
            if (w_taken && !w_misalign) r_redirect_pc <= w_target;
         end
         // Down-counter loaded with the remaining flush cycles after the first.
         if (r_state == S_REDIRECT && redirect_ready)
            r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
         else if (r_state == S_FLUSH && r_flush_cnt != '0)
            r_flush_cnt <= r_flush_cnt - FC_W'(1);
      end
   end

   assign cmp_rs1_value = r_rs1;
   assign cmp_rs2_value = r_rs2;
   assign redirect_pc   = r_redirect_pc;
   assign branch_count  = r_branch_count;
   assign taken_count   = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit with a registered
// comparator model standing in for the real flag generator.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br_valid = 1'b0;
   logic        br_ready;
   logic [2:0]  br_funct3 = 3'b0;
   logic        br_is_jal = 1'b0;
   logic        br_is_jalr = 1'b0;
   logic [31:0] br_pc = '0;
   logic [31:0] br_imm = '0;
   logic [31:0] rs1_in = '0;
   logic [31:0] rs2_in = '0;
   logic [31:0] cmp_rs1_value;
   logic [31:0] cmp_rs2_value;
   logic        enable_branch_cmp;
   logic        EQ_flag = 1'b0;
   logic        LT_flag = 1'b0;
   logic        LTU_flag = 1'b0;
   logic        redirect_valid;
   logic        redirect_ready = 1'b0;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        link_valid;
   logic [31:0] link_pc;
   logic        misalign_exc;
   logic        illegal_br;
   logic [31:0] branch_count;
   logic [31:0] taken_count;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_br = 0;
   int exp_tk = 0;

   branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .br_valid(br_valid), .br_ready(br_ready), .br_funct3(br_funct3),
      .br_is_jal(br_is_jal), .br_is_jalr(br_is_jalr), .br_pc(br_pc),
      .br_imm(br_imm), .rs1_in(rs1_in), .rs2_in(rs2_in),
      .cmp_rs1_value(cmp_rs1_value), .cmp_rs2_value(cmp_rs2_value),
      .enable_branch_cmp(enable_branch_cmp),
      .EQ_flag(EQ_flag), .LT_flag(LT_flag), .LTU_flag(LTU_flag),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc), .flush(flush),
      .link_valid(link_valid), .link_pc(link_pc),
      .misalign_exc(misalign_exc), .illegal_br(illegal_br),
      .branch_count(branch_count), .taken_count(taken_count)
   );

   always #5 clk = ~clk;

   // Comparator registers its flags on the edge that ends an enabled cycle.
   always @(posedge clk) begin
      if (enable_branch_cmp) begin
         EQ_flag  <= (cmp_rs1_value == cmp_rs2_value);
         LT_flag  <= ($signed(cmp_rs1_value) < $signed(cmp_rs2_value));
         LTU_flag <= (cmp_rs1_value < cmp_rs2_value);
      end
   end

   typedef struct {
      logic [2:0]  f3;
      logic        jal;
      logic        jalr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        taken;
      logic        illegal;
      logic        misal;
      logic [31:0] target;
   } vec_t;

   vec_t vecs[14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input vec_t v);
      br_valid   = 1'b1;
      br_funct3  = v.f3;
      br_is_jal  = v.jal;
      br_is_jalr = v.jalr;
      br_pc      = v.pc;
      br_imm     = v.imm;
      rs1_in     = v.rs1;
      rs2_in     = v.rs2;
      tick();
      br_valid   = 1'b0;
      rs1_in     = 32'hDEAD_BEEF;
      rs2_in     = 32'h1234_5678;
   endtask

   task automatic run_vec(input int i);
      vec_t        v;
      logic [31:0] exp_link;
      logic        redir;
      v        = vecs[i];
      exp_link = v.pc + 32'd4;
      redir    = v.taken & ~v.misal;
      chk($sformatf("v%0d_ready_idle", i), br_ready, 1);
      drive_req(v);
      chk($sformatf("v%0d_cmp_en", i), enable_branch_cmp, 1);
      chk($sformatf("v%0d_cmp_rs1", i), cmp_rs1_value, v.rs1);
      chk($sformatf("v%0d_cmp_rs2", i), cmp_rs2_value, v.rs2);
      chk($sformatf("v%0d_busy", i), br_ready, 0);
      tick();
      chk($sformatf("v%0d_en_off", i), enable_branch_cmp, 0);
      chk($sformatf("v%0d_link_valid", i), link_valid, v.jal | v.jalr);
      if (v.jal | v.jalr) chk($sformatf("v%0d_link_pc", i), link_pc, exp_link);
      chk($sformatf("v%0d_illegal", i), illegal_br, v.illegal);
      chk($sformatf("v%0d_misalign", i), misalign_exc, v.misal);
      exp_br++;
      if (v.taken) exp_tk++;
      tick();
      chk($sformatf("v%0d_redirect_valid", i), redirect_valid, redir);
      chk($sformatf("v%0d_branch_count", i), branch_count, exp_br);
      chk($sformatf("v%0d_taken_count", i), taken_count, exp_tk);
      chk($sformatf("v%0d_no_pulse", i), {link_valid, illegal_br, misalign_exc}, 0);
      if (redir) begin
         chk($sformatf("v%0d_redirect_pc", i), redirect_pc, v.target);
         redirect_ready = 1'b1;
         tick();
         redirect_ready = 1'b0;
         chk($sformatf("v%0d_flush1", i), flush, 1);
         chk($sformatf("v%0d_rv_drop", i), redirect_valid, 0);
         tick();
         chk($sformatf("v%0d_flush2", i), flush, 1);
         tick();
         chk($sformatf("v%0d_flush_end", i), flush, 0);
         chk($sformatf("v%0d_ready_back", i), br_ready, 1);
      end else begin
         chk($sformatf("v%0d_ready_back", i), br_ready, 1);
         chk($sformatf("v%0d_no_flush", i), flush, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //          f3      jal   jalr  pc            imm           rs1           rs2           tk    il    mis   target
      vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0020, 32'h5,         32'h5,         1'b1, 1'b0, 1'b0, 32'h0000_0120};
      vecs[1]  = '{3'b001, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0020, 32'h5,         32'h5,         1'b0, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{3'b100, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0040, 32'hFFFF_FFFF, 32'h1,         1'b1, 1'b0, 1'b0, 32'h0000_0340};
      vecs[3]  = '{3'b110, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0040, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{3'b101, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0010, 32'h1,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0410};
      vecs[5]  = '{3'b111, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0010, 32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{3'b000, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0006, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0006};
      vecs[7]  = '{3'b010, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0008, 32'h7,         32'h7,         1'b0, 1'b1, 1'b0, 32'h0};
      vecs[8]  = '{3'b011, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0008, 32'h7,         32'h9,         1'b0, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{3'b000, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0004};
      vecs[10] = '{3'b010, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0020};
      vecs[11] = '{3'b001, 1'b0, 1'b0, 32'h0000_1000, 32'hFFFF_FFF0, 32'h3,         32'h4,         1'b1, 1'b0, 1'b0, 32'h0000_0FF0};
      vecs[12] = '{3'b000, 1'b0, 1'b1, 32'h0000_0050, 32'h0000_0000, 32'h0000_0103, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0102};
      vecs[13] = '{3'b100, 1'b0, 1'b0, 32'h0000_0600, 32'h0000_0008, 32'h5,         32'h3,         1'b0, 1'b0, 1'b0, 32'h0};

      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", br_ready, 1);
      chk("rst_outs", {enable_branch_cmp, redirect_valid, flush, link_valid,
                       misalign_exc, illegal_br}, 0);
      chk("rst_vals", {redirect_pc, link_pc}, 0);
      chk("rst_cnt", {branch_count, taken_count}, 0);

      // Fetch-ready while nothing is pending must not start anything.
      redirect_ready = 1'b1;
      tick();
      tick();
      chk("idle_rdy_ignored", {redirect_valid, flush}, 0);
      chk("idle_rdy_ready", br_ready, 1);
      redirect_ready = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(i);

      // JALR with fetch stalling redirect for five cycles.
      v = '{3'b000, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0004, 32'h0000_1001, 32'h0,
            1'b1, 1'b0, 1'b0, 32'h0000_1004};
      drive_req(v);
      tick();
      chk("jalr_link_valid", link_valid, 1);
      chk("jalr_link_pc", link_pc, 32'h0000_0204);
      exp_br++;
      exp_tk++;
      tick();
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("jalr_stall%0d_rv", c), redirect_valid, 1);
         chk($sformatf("jalr_stall%0d_pc", c), redirect_pc, 32'h0000_1004);
         chk($sformatf("jalr_stall%0d_flush", c), flush, 0);
         tick();
      end
      chk("jalr_rv_held", redirect_valid, 1);
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      chk("jalr_flush1", flush, 1);
      tick();
      chk("jalr_flush2", flush, 1);
      tick();
      chk("jalr_idle", {br_ready, flush}, 2'b10);
      chk("jalr_counts", {branch_count, taken_count}, {exp_br[31:0], exp_tk[31:0]});

      // Reset while a redirect is pending aborts everything.
      v = vecs[0];
      drive_req(v);
      tick();
      tick();
      chk("abort_in_redirect", redirect_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_br = 0;
      exp_tk = 0;
      chk("abort_rv", redirect_valid, 0);
      chk("abort_flush", flush, 0);
      chk("abort_ready", br_ready, 1);
      chk("abort_counts", {branch_count, taken_count}, 0);
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      chk("abort_stays_idle", {redirect_valid, flush, br_ready}, 3'b001);

      run_vec(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
